// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU bus masters (control and program_loader):
// default bus/address widths, the loader FSM state type and the bus-strobe
// encoding both masters use, so the top-level bus mux decodes them the same way.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W = 8;
    localparam int unsigned CPU_ADDR_W = 4;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_WAIT_BYTE,
        LD_ADDR,
        LD_DATA,
        LD_FINISH
    } loader_state_t;

    // One bus cycle: who drives, and which register latches the bus.
    typedef struct packed {
        logic drive;
        logic mar_load;
        logic ram_load;
    } bus_strobe_t;

    localparam bus_strobe_t STROBE_NONE = '{drive: 1'b0, mar_load: 1'b0, ram_load: 1'b0};
    localparam bus_strobe_t STROBE_MAR  = '{drive: 1'b1, mar_load: 1'b1, ram_load: 1'b0};
    localparam bus_strobe_t STROBE_RAM  = '{drive: 1'b1, mar_load: 1'b0, ram_load: 1'b1};

endpackage

// File: rtl/loader_byte_buf.sv
// Single-entry capture register between the byte source and the loader write
// sequence. Accepts a byte (and its last flag) only while capture is enabled,
// so a byte offered while not ready stays with the source.
module loader_byte_buf
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_en_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              take_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // Handshake: ready follows the enable, a transfer happens on valid&ready.
    always_comb begin
        in_ready_o = capture_en_i;
        take_o     = capture_en_i & in_valid_i;
    end

    // Capture register, clocked on the same negedge as the loader FSM.
    always_ff @(negedge clk) begin
        if (rst) begin
            data_q <= '0;
            last_q <= 1'b0;
        end else if (take_o) begin
            data_q <= in_data_i;
            last_q <= in_last_i;
        end
    end

    assign data_o = data_q;
    assign last_o = last_q;

endmodule

// File: rtl/program_loader.sv
// Bus-master program loader: writes a byte stream into program RAM using the
// same MAR-load / RAM-load strobe pair as the fetch/store microcode, holding
// the CPU in reset while it owns the bus.
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN adds checksum, expected_sum
// and sum_ok; a failed checksum keeps the CPU held after the load.
module program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = CPU_ADDR_W,
    parameter int unsigned DATA_W   = CPU_DATA_W,
    parameter int unsigned PROG_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic              mar_read_from_bus,
    output logic              ram_read_from_bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0] expected_sum,
    output logic [DATA_W-1:0] checksum,
    output logic              sum_ok
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              capture_en;
    logic              take;
    logic [DATA_W-1:0] buf_data;
    logic              buf_last;
    logic              end_of_load;
    bus_strobe_t       strobe;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_q;
    logic              sum_ok_q;
    logic              hold_fail_q;
    logic              sum_match;
    assign sum_match = (cksum_q == expected_sum);
`endif

    loader_byte_buf #(
        .DATA_W(DATA_W)
    ) u_byte_buf (
        .clk          (clk),
        .rst          (rst),
        .capture_en_i (capture_en),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .in_ready_o   (in_ready),
        .take_o       (take),
        .data_o       (buf_data),
        .last_o       (buf_last)
    );

    // The byte being written in DATA closes the load on its last flag or on the length limit.
    assign end_of_load = buf_last || ((count_q + 1'b1) == CNT_W'(PROG_LEN));

    // State register, negedge to line up with the control step counter.
    always_ff @(negedge clk) begin
        if (rst) state_q <= LD_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LD_IDLE:      if (start) state_d = LD_WAIT_BYTE;
            LD_WAIT_BYTE: if (take)  state_d = LD_ADDR;
            LD_ADDR:      state_d = LD_DATA;
            LD_DATA:      state_d = end_of_load ? LD_FINISH : LD_WAIT_BYTE;
            LD_FINISH:    state_d = LD_IDLE;
            default:      state_d = LD_IDLE;
        endcase
    end

    // Load bookkeeping: count, write address, sticky done and optional checksum.
    // addr_q may wrap after the final byte of a full-depth load; it is cleared
    // by the next start before it is used again.
    always_ff @(negedge clk) begin
        if (rst) begin
            count_q <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            cksum_q     <= '0;
            sum_ok_q    <= 1'b0;
            hold_fail_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                LD_IDLE: begin
                    if (start) begin
                        count_q <= '0;
                        addr_q  <= '0;
                        done_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        cksum_q     <= '0;
                        sum_ok_q    <= 1'b0;
                        hold_fail_q <= 1'b0;
`endif
                    end
                end
                LD_DATA: begin
                    count_q <= count_q + 1'b1;
                    addr_q  <= addr_q + 1'b1;
                    if (end_of_load) done_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    cksum_q <= cksum_q + buf_data;
`endif
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                LD_FINISH: begin
                    sum_ok_q    <= sum_match;
                    hold_fail_q <= ~sum_match;
                end
`endif
                default: ;
            endcase
        end
    end

    // Output decode from state: bus ownership, strobes and status.
    always_comb begin
        strobe     = STROBE_NONE;
        bus_out    = '0;
        capture_en = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            LD_WAIT_BYTE: begin
                capture_en = 1'b1;
                busy       = 1'b1;
            end
            LD_ADDR: begin
                strobe  = STROBE_MAR;
                bus_out = DATA_W'(addr_q);
                busy    = 1'b1;
            end
            LD_DATA: begin
                strobe  = STROBE_RAM;
                bus_out = buf_data;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus_drive         = strobe.drive;
    assign mar_read_from_bus = strobe.mar_load;
    assign ram_read_from_bus = strobe.ram_load;
    assign done              = done_q;
    assign byte_count        = count_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign checksum = cksum_q;
    assign sum_ok   = (state_q == LD_FINISH) ? sum_match : sum_ok_q;
    assign cpu_hold = busy | ((state_q == LD_FINISH) & ~sum_match) | hold_fail_q;
`else
    assign cpu_hold = busy;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a bus-side MAR/RAM model records
// what the loader writes, and expectations come from the load rules (image
// ends on in_last or at PROG_LEN, writes go to addresses 0,1,2,...).
// Build with PROGRAM_LOADER_CHECKSUM_EN to also cover the checksum ports.
module tb_program_loader;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PROG_LEN = 16;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] bus_out;
    logic              bus_drive;
    logic              mar_read_from_bus;
    logic              ram_read_from_bus;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   byte_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] expected_sum = '0;
    logic [DATA_W-1:0] checksum;
    logic              sum_ok;
`endif

    program_loader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PROG_LEN(PROG_LEN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .bus_out           (bus_out),
        .bus_drive         (bus_drive),
        .mar_read_from_bus (mar_read_from_bus),
        .ram_read_from_bus (ram_read_from_bus),
        .cpu_hold          (cpu_hold),
        .busy              (busy),
        .done              (done),
        .byte_count        (byte_count)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        .expected_sum      (expected_sum),
        .checksum          (checksum),
        .sum_ok            (sum_ok)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Bus-side model: MAR and RAM latch on the posedge in the middle of a step.
    logic [DATA_W-1:0] ram_m [DEPTH];
    logic [ADDR_W-1:0] mar_m = '0;
    logic [DATA_W-1:0] addr_trace [$];
    int unsigned       wr_cnt = 0;

    always @(posedge clk) begin
        if (mar_read_from_bus || ram_read_from_bus) begin
            check("strobe_exclusive", {31'd0, mar_read_from_bus & ram_read_from_bus}, 32'd0);
            check("strobe_needs_drive", {31'd0, bus_drive}, 32'd1);
        end
        if (in_ready)
            check("quiet_while_waiting", {29'd0, bus_drive, mar_read_from_bus, ram_read_from_bus}, 32'd0);
        if (mar_read_from_bus) begin
            mar_m = bus_out[ADDR_W-1:0];
            addr_trace.push_back(bus_out);
        end
        if (ram_read_from_bus) begin
            ram_m[mar_m] = bus_out;
            wr_cnt++;
        end
    end

    // Image to send.
    logic [DATA_W-1:0] tx_data [32];
    bit                tx_last [32];
    int unsigned       tx_n;

    function automatic logic [DATA_W-1:0] bg(input int unsigned a);
        return DATA_W'(8'hA5 ^ a);
    endfunction

    // Bytes the loader should write: up to and including the first last-flag, capped at PROG_LEN.
    function automatic int unsigned model_len();
        for (int unsigned i = 0; i < tx_n; i++)
            if (tx_last[i] || (i + 1 == PROG_LEN)) return i + 1;
        return tx_n;
    endfunction

    task automatic clear_model();
        for (int unsigned a = 0; a < DEPTH; a++) ram_m[a] = bg(a);
        addr_trace.delete();
        wr_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Source side: offer bytes in order, holding each until the loader is ready.
    task automatic feed(input int unsigned stall, input bit noise);
        int unsigned budget;
        for (int unsigned i = 0; i < tx_n; i++) begin
            if (stall > 0 && i > 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                for (int unsigned s = 0; s < stall; s++) begin
                    start = noise && (s == 3) && !done;
                    @(posedge clk); #1;
                end
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = tx_data[i];
            in_last  = tx_last[i];
            budget   = 0;
            while (!in_ready && !done && budget < 64) begin
                @(posedge clk); #1;
                budget++;
            end
            if (done) break;
            if (budget >= 64) begin
                check("feed_timeout", budget, 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Watches for the final write and checks the release timing of the next cycle.
    task automatic watch_finish(input int unsigned exp_n, input bit exp_hold);
        int unsigned budget = 0;
        while (wr_cnt < exp_n && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 2000) begin
            check("finish_timeout", wr_cnt, exp_n);
        end else begin
            check("hold_in_last_data", {31'd0, cpu_hold}, 32'd1);
            @(posedge clk); #1;
            check("hold_after_last_data", {31'd0, cpu_hold}, {31'd0, exp_hold});
            check("done_in_finish", {31'd0, done}, 32'd1);
            check("busy_in_finish", {31'd0, busy}, 32'd0);
            check("drive_in_finish", {31'd0, bus_drive}, 32'd0);
        end
    endtask

    task automatic run_load(input string tag, input int unsigned stall, input bit noise,
                            input int unsigned exp_cnt, input bit sum_good);
        int unsigned       exp_n;
        logic [DATA_W-1:0] sum_m;
        exp_n = model_len();
        sum_m = '0;
        for (int unsigned i = 0; i < exp_n; i++) sum_m = sum_m + tx_data[i];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        expected_sum = sum_good ? sum_m : sum_m + 8'd1;
`endif
        clear_model();
        pulse_start();
        fork
            feed(stall, noise);
            watch_finish(exp_n, !sum_good);
        join
        repeat (2) begin @(posedge clk); #1; end
        check({tag, "_byte_count"}, byte_count, exp_cnt);
        check({tag, "_writes"}, wr_cnt, exp_n);
        check({tag, "_done_sticky"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold_idle"}, {31'd0, cpu_hold}, {31'd0, !sum_good});
        check({tag, "_trace_len"}, addr_trace.size(), exp_n);
        for (int unsigned k = 0; k < addr_trace.size() && k < exp_n; k++)
            check({tag, "_addr_order"}, addr_trace[k], k);
        for (int unsigned a = 0; a < DEPTH; a++)
            check({tag, "_ram"}, ram_m[a], (a < exp_n) ? tx_data[a] : bg(a));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, sum_m);
        check({tag, "_sum_ok"}, {31'd0, sum_ok}, {31'd0, sum_good});
`endif
    endtask

    typedef struct {
        int unsigned n;
        int          last_idx;
        int unsigned stall;
        bit          noise;
        int unsigned exp_cnt;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [DATA_W-1:0] fixed16 [16];
        int unsigned budget;

        tbl[0] = '{n: 16, last_idx: -1, stall: 0, noise: 1'b0, exp_cnt: 16};
        tbl[1] = '{n: 1,  last_idx: 0,  stall: 0, noise: 1'b0, exp_cnt: 1};
        tbl[2] = '{n: 5,  last_idx: 4,  stall: 5, noise: 1'b0, exp_cnt: 5};
        tbl[3] = '{n: 20, last_idx: -1, stall: 1, noise: 1'b0, exp_cnt: 16};
        tbl[4] = '{n: 18, last_idx: 17, stall: 5, noise: 1'b1, exp_cnt: 16};
        tbl[5] = '{n: 7,  last_idx: 3,  stall: 5, noise: 1'b1, exp_cnt: 4};

        fixed16 = '{8'h51, 8'h2E, 8'h7A, 8'h03, 8'hC4, 8'h99, 8'h18, 8'h6D,
                    8'hB2, 8'h47, 8'hE5, 8'h0C, 8'h3F, 8'h86, 8'hD1, 8'hF0};

        // Reset values.
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_bus", {21'd0, bus_drive, mar_read_from_bus, ram_read_from_bus, bus_out}, 32'd0);
        check("rst_status", {29'd0, cpu_hold, busy, done}, 32'd0);
        check("rst_byte_count", byte_count, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full 16-byte image, source always valid.
        tx_n = 16;
        for (int unsigned i = 0; i < 16; i++) begin
            tx_data[i] = fixed16[i];
            tx_last[i] = 1'b0;
        end
        run_load("full16", 0, 1'b0, 16, 1'b1);

        // Early end on byte 3.
        tx_n = 3;
        tx_data[0] = 8'h1E; tx_data[1] = 8'hE0; tx_data[2] = 8'hF0;
        tx_last[0] = 1'b0;  tx_last[1] = 1'b0;  tx_last[2] = 1'b1;
        run_load("last3", 0, 1'b0, 3, 1'b1);

        // Randomised images, stalls and stray start pulses.
        for (int unsigned v = 0; v < 6; v++) begin
            tx_n = tbl[v].n;
            for (int unsigned i = 0; i < tx_n; i++) begin
                tx_data[i] = DATA_W'($urandom);
                tx_last[i] = (int'(i) == tbl[v].last_idx);
            end
            run_load($sformatf("vec%0d", v), tbl[v].stall, tbl[v].noise, tbl[v].exp_cnt, 1'b1);
        end

        // Reset during the DATA step of byte 4.
        clear_model();
        pulse_start();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_last  = 1'b0;
        budget   = 0;
        while (wr_cnt < 4 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("midrst_reached_byte4", wr_cnt, 32'd4);
        check("midrst_in_data", {31'd0, ram_read_from_bus}, 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_status", {29'd0, cpu_hold, busy, done}, 32'd0);
        check("midrst_bus_drive", {31'd0, bus_drive}, 32'd0);
        check("midrst_byte_count", byte_count, 32'd0);
        rst = 1'b0;
        for (int unsigned a = 0; a < 4; a++) check("midrst_partial_ram", ram_m[a], 8'h3C);
        tx_n = 3;
        for (int unsigned i = 0; i < 3; i++) begin
            tx_data[i] = DATA_W'($urandom);
            tx_last[i] = (i == 2);
        end
        run_load("after_rst", 2, 1'b0, 3, 1'b1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tx_n = 2;
        tx_data[0] = 8'h80; tx_data[1] = 8'h90;
        tx_last[0] = 1'b0;  tx_last[1] = 1'b1;
        run_load("sum_good", 0, 1'b0, 2, 1'b1);
        check("sum_good_expected", expected_sum, 8'h10);
        run_load("sum_bad", 0, 1'b0, 2, 1'b0);
        check("sum_bad_expected", expected_sum, 8'h11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Bus-master writer that fills program RAM from a byte stream, so a program can be loaded without resynthesis.
- Sits beside `control` on the shared 8-bit bus.
- While loading, it holds the CPU in reset and is the only bus driver. Per byte, it issues the same MAR-load then RAM-load strobe sequence that the fetch/store microcode uses.
- Releases the CPU when the image is complete.

Parameters:
- ADDR_W, 4, RAM address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, bus and byte width.
- PROG_LEN, 16, maximum bytes per load; legal range 1..2**ADDR_W.

Ports:
- clk  in  1  system clock; state advances on negedge, matching the control step counter.
- rst  in  1  reset (synchronous, active-high).
- start  in  1  begin a load; sampled in IDLE only.
- in_valid  in  1  in_data holds a byte.
- in_data  in  DATA_W  program byte.
- in_last  in  1  qualifies in_data as the final byte (early end).
- in_ready  out  1  loader accepts byte this cycle.
- bus_out  out  DATA_W  value driven onto the shared bus.
- bus_drive  out  1  loader owns the bus; top-level mux selects bus_out.
- mar_read_from_bus  out  1  MAR latches bus.
- ram_read_from_bus  out  1  RAM latches bus at MAR address.
- cpu_hold  out  1  forces CPU reset / clock gate.
- busy  out  1  load in progress.
- done  out  1  sticky: last load completed.
- byte_count  out  ADDR_W+1  bytes written in current/last load.

Behaviour:
- Reset values: in_ready=0, bus_drive=0, strobes=0, bus_out=0, cpu_hold=0, busy=0, done=0, byte_count=0, address=0. FSM=IDLE.
- FSM states: IDLE, WAIT_BYTE, ADDR, DATA, FINISH. All registered on negedge; outputs decode from state.
- IDLE:
  - start=1 -> WAIT_BYTE. Clear byte_count, address and done. Set busy=1, cpu_hold=1.
  - start is ignored in every other state.
- WAIT_BYTE:
  - in_ready=1.
  - in_valid=1 -> capture in_data into a byte register and capture in_last -> ADDR.
  - in_valid=0 -> stay. There is no timeout.
- ADDR (1 cycle):
  - bus_drive=1, bus_out = zero-extended address, mar_read_from_bus=1 -> DATA.
- DATA (1 cycle):
  - bus_drive=1, bus_out = captured byte, ram_read_from_bus=1.
  - Increment byte_count and address.
  - If captured last, or byte_count+1 == PROG_LEN -> FINISH; else -> WAIT_BYTE.
- FINISH (1 cycle):
  - Bus released. busy=0, cpu_hold=0, done=1 -> IDLE.
  - done stays 1 until the next start.
- Throughput: 3 cycles minimum per byte (handshake, ADDR, DATA).
- Strobe rules: mar_read_from_bus and ram_read_from_bus are never high in the same cycle. Neither strobe is high unless bus_drive=1.
- Boundaries:
  - Length limit: the byte that makes byte_count == PROG_LEN ends the load, even if in_last=0.
  - Address never wraps within a load.
  - in_last on the first byte: a 1-byte load, byte_count=1.
  - in_valid while in_ready=0 is not consumed; the source must hold it.
- Reset mid-load: next negedge returns to IDLE with all reset values. cpu_hold drops and the partially written RAM is left as-is. done=0.
- Because cpu_hold=1 throughout busy, the CPU step counter cannot contend for the bus.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Adds output checksum [DATA_W-1:0]: the mod-2**DATA_W sum of all bytes written in the current/last load.
  - Cleared at start and at reset; updated in DATA.
  - Adds input expected_sum [DATA_W-1:0] and output sum_ok.
  - sum_ok is evaluated in FINISH as checksum==expected_sum and held with done.
  - If sum_ok=0, cpu_hold stays 1 after FINISH until the next start or rst.
- Without the macro: the ports are absent, and cpu_hold always releases in FINISH.

Decomposition:
- Shared package cpu_pkg holds:
  - the FSM state enum loader_state_t;
  - DATA_W/ADDR_W defaults;
  - bus-strobe constants shared with control, so the bus mux decodes both masters consistently.
- One natural sub-module: loader_byte_buf. It is the single-entry capture register with valid/ready and a last flag, and it decouples the source handshake from the write sequence.

Test Plan:
- Full load of 16 bytes 0x51,0x2E,...,0xF0, in_valid always high:
  - expect 16 ADDR/DATA pairs, with bus_out addresses 0x00..0x0F in order;
  - RAM contents match the sent bytes; byte_count=16;
  - done=1 and cpu_hold falls exactly 1 cycle after the last DATA.
- 3-byte load with in_last on byte 3 (0x1E, 0xE0, 0xF0):
  - RAM[0..2] written and RAM[3..15] untouched;
  - byte_count=3, done=1.
- Source stalls, with in_valid low for 5 cycles between bytes:
  - loader stays in WAIT_BYTE with in_ready=1;
  - no strobes fire; data is intact.
- rst asserted during DATA of byte 4:
  - next cycle busy=0, cpu_hold=0, done=0, bus_drive=0;
  - a new start then writes from address 0.
- start pulsed while busy=1: no effect on address or byte_count.
- With PROGRAM_LOADER_CHECKSUM_EN, bytes 0x80,0x90 and expected_sum=0x10:
  - sum_ok=1 and cpu_hold released;
  - with expected_sum=0x11, sum_ok=0 and cpu_hold stays 1.
